// File: rtl/jericalla_pkg.sv
// Shared types and helpers for the jericalla_pipe core: opcode enum, instruction
// field offsets (as functions of AW) and opcode classification.
package jericalla_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_ADD = 3'b001,
    OP_SUB = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_LDI = 3'b101,
    OP_SW  = 3'b110,
    OP_LW  = 3'b111
  } op_e;

  function automatic int instr_w(input int aw);
    return 3 + 3 * aw;
  endfunction

  function automatic int op_lsb(input int aw);
    return 3 * aw;
  endfunction

  function automatic int wa_lsb(input int aw);
    return 2 * aw;
  endfunction

  function automatic int ra1_lsb(input int aw);
    return aw;
  endfunction

  function automatic logic op_writes_reg(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_LDI) || (op == OP_LW);
  endfunction

  function automatic logic op_reads_a(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
           (op == OP_SW);
  endfunction

  // LW uses only ra2 (the address register); LDI reuses both fields as immediate.
  function automatic logic op_reads_b(input op_e op);
    return op_reads_a(op) || (op == OP_LW);
  endfunction

  function automatic logic op_sets_zf(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/jericalla_regfile.sv
// 2-read/1-write register file with asynchronous clear and write-through,
// so a write landing this cycle is seen by the same-cycle reads.
module jericalla_regfile #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_jericalla,
  input  logic          rst_n_jericalla,
  input  logic          i_we,
  input  logic [AW-1:0] i_wa,
  input  logic [DW-1:0] i_wd,
  input  logic [AW-1:0] i_ra1,
  input  logic [AW-1:0] i_ra2,
  output logic [DW-1:0] o_rd1,
  output logic [DW-1:0] o_rd2
);
  localparam int NREG = 2 ** AW;

  logic [DW-1:0] r_regs [NREG];

  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_we && (i_wa == i_ra1)) ? i_wd : r_regs[i_ra1];
  assign o_rd2 = (i_we && (i_wa == i_ra2)) ? i_wd : r_regs[i_ra2];

endmodule

// File: rtl/jericalla_pipe.sv
// Three-stage issue/execute/memory-writeback register+ALU+RAM core.
// Define JERICALLA_FWD_EN to forward S2 ALU results into S1 (only LW dependents stall).
module jericalla_pipe
  import jericalla_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int MEM_AW  = 6,
  parameter int INSTR_W = instr_w(AW)
) (
  input  logic               clk_jericalla,
  input  logic               rst_n_jericalla,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instruccion,
  output logic               wb_valid,
  output logic [AW-1:0]      wb_addr,
  output logic [DW-1:0]      dataOut_jericalla,
  output logic               zf_jericalla
);
  localparam int OP_LSB  = op_lsb(AW);
  localparam int WA_LSB  = wa_lsb(AW);
  localparam int RA1_LSB = ra1_lsb(AW);

  // S1 decode
  op_e             w_s1_op;
  logic [AW-1:0]   w_s1_wa, w_s1_ra1, w_s1_ra2;
  logic [DW-1:0]   w_imm, w_rf_rd1, w_rf_rd2, w_opa, w_opb;
  logic            w_match_a, w_match_b, w_s2_writes, w_stall, w_accept;

  // B1 (S2 inputs)
  logic            r_b1_valid;
  op_e             r_b1_op;
  logic [AW-1:0]   r_b1_wa;
  logic [DW-1:0]   r_b1_a, r_b1_b;
  logic [DW-1:0]   w_alu_res;

  // B2 (S3 inputs)
  logic            r_b2_valid;
  op_e             r_b2_op;
  logic [AW-1:0]   r_b2_wa;
  logic [DW-1:0]   r_b2_res, r_b2_sd;
  logic [MEM_AW-1:0] w_mem_addr;
  logic [DW-1:0]   w_mem_rd, w_wb_data;
  logic            w_rf_we, w_mem_we, w_retire;

  logic [DW-1:0]   r_mem [2**MEM_AW];

  assign w_s1_op  = op_e'(instruccion[OP_LSB +: 3]);
  assign w_s1_wa  = instruccion[WA_LSB +: AW];
  assign w_s1_ra1 = instruccion[RA1_LSB +: AW];
  assign w_s1_ra2 = instruccion[0 +: AW];
  assign w_imm    = DW'({w_s1_ra1, w_s1_ra2});

  jericalla_regfile #(.DW(DW), .AW(AW)) u_regfile (
    .clk_jericalla   (clk_jericalla),
    .rst_n_jericalla (rst_n_jericalla),
    .i_we            (w_rf_we),
    .i_wa            (r_b2_wa),
    .i_wd            (w_wb_data),
    .i_ra1           (w_s1_ra1),
    .i_ra2           (w_s1_ra2),
    .o_rd1           (w_rf_rd1),
    .o_rd2           (w_rf_rd2)
  );

  // Only the B1 producer can conflict; the B2 producer reaches S1 via write-through.
  assign w_match_a   = op_reads_a(w_s1_op) && (w_s1_ra1 == r_b1_wa);
  assign w_match_b   = op_reads_b(w_s1_op) && (w_s1_ra2 == r_b1_wa);
  assign w_s2_writes = r_b1_valid && op_writes_reg(r_b1_op);

`ifdef JERICALLA_FWD_EN
  logic w_fwd_ok;
  assign w_fwd_ok = w_s2_writes && (r_b1_op != OP_LW);
  assign w_stall  = w_s2_writes && (r_b1_op == OP_LW) && (w_match_a || w_match_b);
  assign w_opa    = (w_fwd_ok && w_match_a) ? w_alu_res : w_rf_rd1;
  assign w_opb    = (w_s1_op == OP_LDI) ? w_imm :
                    (w_fwd_ok && w_match_b) ? w_alu_res : w_rf_rd2;
`else
  assign w_stall  = w_s2_writes && (w_match_a || w_match_b);
  assign w_opa    = w_rf_rd1;
  assign w_opb    = (w_s1_op == OP_LDI) ? w_imm : w_rf_rd2;
`endif

  assign instr_ready = rst_n_jericalla && !w_stall;
  assign w_accept    = instr_valid && instr_ready;

  // S2: for SW/LW the result is the memory address (operand b)
  always_comb begin
    w_alu_res = '0;
    case (r_b1_op)
      OP_ADD:               w_alu_res = r_b1_a + r_b1_b;
      OP_SUB:               w_alu_res = r_b1_a - r_b1_b;
      OP_AND:               w_alu_res = r_b1_a & r_b1_b;
      OP_OR:                w_alu_res = r_b1_a | r_b1_b;
      OP_LDI, OP_SW, OP_LW: w_alu_res = r_b1_b;
      default:              w_alu_res = '0;
    endcase
  end

  assign w_mem_addr = r_b2_res[MEM_AW-1:0];
  assign w_mem_rd   = r_mem[w_mem_addr];
  assign w_wb_data  = (r_b2_op == OP_LW) ? w_mem_rd : r_b2_res;
  assign w_rf_we    = r_b2_valid && op_writes_reg(r_b2_op);
  assign w_mem_we   = r_b2_valid && (r_b2_op == OP_SW);
  assign w_retire   = r_b2_valid && (r_b2_op != OP_NOP);

  always_ff @(posedge clk_jericalla or negedge rst_n_jericalla) begin
    if (!rst_n_jericalla) begin
      r_b1_valid        <= 1'b0;
      r_b1_op           <= OP_NOP;
      r_b1_wa           <= '0;
      r_b1_a            <= '0;
      r_b1_b            <= '0;
      r_b2_valid        <= 1'b0;
      r_b2_op           <= OP_NOP;
      r_b2_wa           <= '0;
      r_b2_res          <= '0;
      r_b2_sd           <= '0;
      wb_valid          <= 1'b0;
      wb_addr           <= '0;
      dataOut_jericalla <= '0;
      zf_jericalla      <= 1'b0;
    end else begin
      r_b1_valid <= w_accept;
      r_b1_op    <= w_s1_op;
      r_b1_wa    <= w_s1_wa;
      r_b1_a     <= w_opa;
      r_b1_b     <= w_opb;

      r_b2_valid <= r_b1_valid;
      r_b2_op    <= r_b1_op;
      r_b2_wa    <= r_b1_wa;
      r_b2_res   <= w_alu_res;
      r_b2_sd    <= r_b1_a;

      wb_valid <= w_retire;
      if (w_retire) begin
        wb_addr           <= (r_b2_op == OP_SW) ? '0 : r_b2_wa;
        dataOut_jericalla <= (r_b2_op == OP_SW) ? r_b2_sd : w_wb_data;
      end
      if (r_b2_valid && op_sets_zf(r_b2_op)) begin
        zf_jericalla <= (r_b2_res == '0);
      end
    end
  end

  // RAM contents are deliberately not cleared by reset
  always_ff @(posedge clk_jericalla) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= r_b2_sd;
    end
  end

endmodule

// File: tb/tb_jericalla_pipe.sv
// Bench for jericalla_pipe: in-order ISA model plus per-cycle compare of writeback outputs.
// Adapts expected stall behaviour to JERICALLA_FWD_EN.
module tb_jericalla_pipe;
  import jericalla_pkg::*;

  localparam int DW = 32, AW = 5, MEM_AW = 6, IW = 3 + 3 * AW;
`ifdef JERICALLA_FWD_EN
  localparam int EXP_ADD_STALL = 0;
`else
  localparam int EXP_ADD_STALL = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [IW-1:0] instruccion = '0;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] dout;
  logic          zf;

  always #5 clk = ~clk;

  jericalla_pipe #(.DW(DW), .AW(AW), .MEM_AW(MEM_AW)) dut (
    .clk_jericalla     (clk),
    .rst_n_jericalla   (rst_n),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instruccion       (instruccion),
    .wb_valid          (wb_valid),
    .wb_addr           (wb_addr),
    .dataOut_jericalla (dout),
    .zf_jericalla      (zf)
  );

  typedef struct {
    int            retire;
    bit            wb;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            zf_upd;
    bit            zf;
  } rec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_t;

  rec_t          exp_q[$];
  wb_t           wb_log[$];
  logic [DW-1:0] m_reg [32];
  logic [DW-1:0] m_mem [64];
  bit            m_zf = 1'b0;
  bit            m_b1_valid = 1'b0;
  logic [IW-1:0] m_b1_ins = '0;
  int            ncyc = 0;
  int            n_vec = 0;
  int            n_miss = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic logic [IW-1:0] mk(input int op, input int wa, input int ra1, input int ra2);
    logic [2:0] o;
    logic [4:0] w, a, b;
    o = op[2:0]; w = wa[4:0]; a = ra1[4:0]; b = ra2[4:0];
    return {o, w, a, b};
  endfunction

  // Instruction just accepted (sitting in the execute stage) vs. the one offered now.
  function automatic bit hazard(input logic [IW-1:0] ins);
    logic [2:0] p, o;
    bit ma, mb;
    p = m_b1_ins[IW-1 -: 3];
    o = ins[IW-1 -: 3];
    if (!m_b1_valid) return 1'b0;
    if (!(p inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7})) return 1'b0;
    ma = (o inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6}) && (ins[9:5] == m_b1_ins[14:10]);
    mb = (o inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7}) && (ins[4:0] == m_b1_ins[14:10]);
`ifdef JERICALLA_FWD_EN
    return (p == 3'd7) && (ma || mb);
`else
    return ma || mb;
`endif
  endfunction

  // Sequential ISA semantics applied at acceptance; the pipeline must reproduce them in order.
  task automatic execute(input logic [IW-1:0] ins);
    rec_t r;
    logic [2:0] op;
    logic [4:0] wa, ra1, ra2;
    logic [DW-1:0] a, b, res;
    op = ins[14+3 -: 3]; wa = ins[14:10]; ra1 = ins[9:5]; ra2 = ins[4:0];
    a = m_reg[ra1]; b = m_reg[ra2]; res = '0;
    r.retire = ncyc + 3;
    r.wb     = (op != 3'd0);
    r.zf_upd = (op >= 3'd1) && (op <= 3'd4);
    r.addr   = wa;
    case (op)
      3'd1: res = a + b;
      3'd2: res = a - b;
      3'd3: res = a & b;
      3'd4: res = a | b;
      3'd5: res = DW'({ra1, ra2});
      3'd6: begin m_mem[b[5:0]] = a; res = a; r.addr = '0; end
      3'd7: res = m_mem[b[5:0]];
      default: res = '0;
    endcase
    if (op inside {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7}) m_reg[wa] = res;
    r.data = res;
    r.zf   = (res == '0);
    exp_q.push_back(r);
  endtask

  task automatic step(input bit v, input logic [IW-1:0] ins, output bit acc);
    bit er;
    @(negedge clk);
    instr_valid = v;
    instruccion = ins;
    #1;
    er = rst_n && !hazard(ins);
    chk("instr_ready", instr_ready, er);
    @(posedge clk);
    acc = v && er;
    if (acc) execute(ins);
    m_b1_valid = acc;
    m_b1_ins   = ins;
  endtask

  task automatic issue(input logic [IW-1:0] ins, output int stalls);
    bit acc;
    acc = 1'b0;
    stalls = 0;
    for (int t = 0; t < 4 && !acc; t++) begin
      step(1'b1, ins, acc);
      if (!acc) stalls++;
    end
    chk("issue_accepted", acc, 1);
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, '0, acc);
  endtask

  task automatic do_reset(input int n);
    #2;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instruccion = '0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_b1_valid = 1'b0;
    repeat (n) begin
      @(negedge clk);
      #1 chk("ready_in_reset", instr_ready, 0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("ready_after_reset", instr_ready, 1);
  endtask

  task automatic chk_log(input string name, input int idx, input int addr, input int data);
    logic [AW-1:0] la;
    logic [DW-1:0] ld;
    la = 'x; ld = 'x;
    if (idx < wb_log.size()) begin la = wb_log[idx].addr; ld = wb_log[idx].data; end
    chk({name, "_addr"}, la, addr[AW-1:0]);
    chk({name, "_data"}, ld, data);
  endtask

  // Compare process: writeback outputs checked every cycle against the model queue.
  always @(negedge clk) begin
    rec_t r;
    wb_t  w;
    ncyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_zf = 1'b0;
      chk("reset_wb_valid", wb_valid, 0);
      chk("reset_wb_addr", wb_addr, 0);
      chk("reset_data", dout, 0);
      chk("reset_zf", zf, 0);
    end else begin
      if (exp_q.size() > 0 && exp_q[0].retire == ncyc) begin
        r = exp_q.pop_front();
        if (r.zf_upd) m_zf = r.zf;
        chk("wb_valid", wb_valid, r.wb);
        if (r.wb) begin
          chk("wb_addr", wb_addr, r.addr);
          chk("wb_data", dout, r.data);
        end
      end else begin
        chk("wb_valid_idle", wb_valid, 0);
      end
      chk("zf", zf, m_zf);
      if (wb_valid) begin
        w.addr = wb_addr;
        w.data = dout;
        wb_log.push_back(w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, s1, s2;
    bit acc;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    do_reset(2);

    // back-to-back LDI/LDI/ADD
    wb_log.delete();
    issue(mk(5, 1, 1, 1), s0);
    issue(mk(5, 2, 0, 5), s1);
    issue(mk(1, 3, 1, 2), s2);
    idle(4);
    chk("t1_stall_ldi", s0 + s1, 0);
    chk("t1_stall_add", s2, EXP_ADD_STALL);
    chk("t1_nret", wb_log.size(), 3);
    chk_log("t1_r1", 0, 1, 'h21);
    chk_log("t1_r2", 1, 2, 'h05);
    chk_log("t1_r3", 2, 3, 'h26);
    chk("t1_zf", zf, 0);

    // SUB to zero sets zf; LDI leaves it
    wb_log.delete();
    issue(mk(2, 4, 1, 1), s0);
    issue(mk(5, 8, 0, 3), s1);
    idle(4);
    chk_log("t2_r4", 0, 4, 0);
    chk_log("t2_r8", 1, 8, 3);
    chk("t2_zf", zf, 1);

    // SW, LW, dependent ADD
    wb_log.delete();
    issue(mk(6, 0, 1, 2), s0);
    issue(mk(7, 5, 0, 2), s1);
    issue(mk(1, 6, 5, 5), s2);
    idle(4);
    chk("t3_stall_sw_lw", s0 + s1, 0);
    chk("t3_stall_add", s2, 1);
    chk_log("t3_sw", 0, 0, 'h21);
    chk_log("t3_r5", 1, 5, 'h21);
    chk_log("t3_r6", 2, 6, 'h42);
    chk("t3_zf", zf, 0);

    // valid gaps and a NOP
    wb_log.delete();
    idle(3);
    issue(mk(0, 9, 9, 9), s0);
    idle(2);
    issue(mk(1, 9, 1, 2), s1);
    idle(4);
    chk("t5_stall", s0 + s1, 0);
    chk("t5_nret", wb_log.size(), 1);
    chk_log("t5_r9", 0, 9, 'h26);

    // reset with two instructions in flight
    wb_log.delete();
    issue(mk(5, 1, 3, 3), s0);
    issue(mk(5, 2, 4, 4), s1);
    do_reset(2);
    idle(3);
    chk("t6_nret", wb_log.size(), 0);
    issue(mk(1, 7, 1, 2), s0);
    idle(4);
    chk_log("t6_r7", 0, 7, 0);
    chk("t6_zf", zf, 1);

    // fill the whole RAM so every later LW reads defined data
    for (int a = 0; a < 64; a++) begin
      issue(mk(5, 30, a >> 5, a & 31), s0);
      issue(mk(5, 31, $urandom_range(0, 31), $urandom_range(0, 31)), s0);
      issue(mk(6, 0, 31, 30), s0);
    end

    // randomized stream with valid gaps
    for (int i = 0; i < 600; i++) begin
      logic [IW-1:0] ins;
      ins = mk($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) step(1'b0, ins, acc);
      else issue(ins, s0);
    end
    idle(4);
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/jericalla_pipe.md
# jericalla_pipe

Parametrised successor to the two-buffer Jericalla datapath. It is a three-stage pipelined register/ALU/RAM core (issue, execute, memory/writeback) with configurable data width, register count and RAM depth. It adds a valid/ready instruction handshake, hazard detection with stall, result forwarding, an immediate-load opcode, reset, and a writeback observation port.

## Interface
- DW, 32: data width of registers, ALU and RAM words
- AW, 5: register address width; 2**AW registers
- MEM_AW, 6: RAM address width; 2**MEM_AW words
- Instruction width is INSTR_W = 3 + 3*AW. Fields: op[INSTR_W-1 -: 3], wa, ra1, ra2 (ra2 in the LSBs).

Ports:
- clk_jericalla  in  1  the single clock; everything samples on its rising edge
- rst_n_jericalla  in  1  reset, asynchronous, active-low
- instr_valid  in  1  instruccion is valid this cycle
- instr_ready  out  1  the block accepts the instruction this cycle
- instruccion  in  INSTR_W  instruction word
- wb_valid  out  1  an instruction retired on the last edge
- wb_addr  out  AW  destination register of the retired write
- dataOut_jericalla  out  DW  value written back, or the store data
- zf_jericalla  out  1  zero flag of the last retired ALU op

## Operation
- Opcodes:
  - 000 NOP.
  - 001 ADD: R[wa] = R[ra1] + R[ra2].
  - 010 SUB: R[wa] = R[ra1] - R[ra2].
  - 011 AND.
  - 100 OR.
  - 101 LDI: R[wa] = zero-extend({ra1, ra2}).
  - 110 SW: mem[R[ra2][MEM_AW-1:0]] = R[ra1].
  - 111 LW: R[wa] = mem[R[ra2][MEM_AW-1:0]].
- Arithmetic wraps modulo 2**DW. Address bits above MEM_AW are ignored.
- Stage S1 (issue): an instruction is accepted when instr_valid && instr_ready. The register file is read and the instruction is captured into buffer B1 with a valid bit.
- Stage S2 (execute): the ALU computes the result or the address, and the instruction is captured into B2.
- Stage S3 (memory/writeback):
  - SW writes the RAM.
  - LW reads the RAM combinationally.
  - ADD/SUB/AND/OR/LDI/LW write R[wa].
- The register file has a write-through path: a write in S3 is visible to the S1 read in the same cycle.
- Hazard: the S1 instruction reads ra1 or ra2 equal to the wa of a writing instruction valid in S2.
- A stall drives instr_ready=0 and inserts a bubble into B1. Stall length is always exactly one cycle.
- NOP and an empty slot produce no writeback. wb_valid=0 for them.
- On a SW retirement: wb_valid=1, wb_addr=0, dataOut_jericalla = the store data, and no register write.
- zf_jericalla updates only when ADD/SUB/AND/OR retires, to (result==0). It holds otherwise.
- All registers are reset to 0. RAM contents are not reset; reading an unwritten word gives undefined data.
- Register 0 is an ordinary register.

## Timing
- An instruction accepted at edge k occupies B1 after k and B2 after k+1. It retires on edge k+2.
- wb_valid, wb_addr, dataOut_jericalla and zf_jericalla are registered. They are valid after edge k+2.
- Throughput is one instruction per cycle when there is no stall.
- instr_ready is combinational from B1/B2 state and instruccion. It does not depend on instr_valid.
- Reset values: instr_ready=0 while reset is asserted, and 1 in the first cycle after release. All other outputs are 0, and all valid bits are 0.
- Reset asserted mid-operation discards in-flight instructions: no RAM write and no register write occur.
- Simultaneous S3 write and S1 read of the same register: S1 gets the new value.

## Configuration
- JERICALLA_FWD_EN defined:
  - S2 results from ADD/SUB/AND/OR/LDI are forwarded into the S1 operands.
  - Only the LW-then-dependent case stalls (one cycle).
- JERICALLA_FWD_EN undefined:
  - There is no forwarding mux.
  - Every S2-writing hazard stalls one cycle.
  - Results are identical; only the stall count differs.

## Structure
- Package jericalla_pkg holds:
  - the opcode enum;
  - the field-offset helper functions parametrised by AW;
  - an `op_writes_reg` function.
- Sub-module jericalla_regfile: 2 read ports, 1 write port, asynchronous clear, write-through.
- The hazard/forward logic, the ALU and the RAM live in the top level.

## Test plan
- LDI r1,0x21; LDI r2,0x05; ADD r3,r1,r2 issued back to back (FWD_EN) -> no stall. Retirements: r1=0x21, r2=0x05, r3=0x26. zf=0.
- SUB r4,r1,r1 -> retires wb_addr=4, data=0, zf=1. A following LDI keeps zf=1.
- SW r1 -> mem[r2=5]; LW r5,[r2]; ADD r6,r5,r5 back to back -> instr_ready low for exactly one cycle before ADD. r5=0x21, r6=0x42.
- Same sequence as the first test without JERICALLA_FWD_EN -> one stall cycle before ADD. r3=0x26.
- instr_valid gaps and a NOP -> no wb_valid pulse for them, instr_ready stays 1, registers unchanged.
- Assert rst_n_jericalla with two instructions in flight -> no wb_valid. All outputs become 0. A later ADD r7,r1,r2 retires 0.
